ccip_intr_scheduler: RTL and testbench

- Schedules user interrupt requests from up to four AFU sources onto the CCI-P c1 TX interrupt path (eREQ_INTR, interrupt id 0..3).
- Latches per-source requests, arbitrates round-robin, and respects c1TxAlmFull.
- Tracks one outstanding interrupt per id until the interrupt response returns, and flags timeouts and spurious responses for CSR readback.
- Sits between the AFU CSR/MMIO logic and the c1 TX mux. The wrapper packs tx_intr_* into a t_ccip_c1_ReqIntrHdr and decodes c1 RX interrupt responses into rx_rsp_*.

---
 rtl/ccip_intr_scheduler.sv | 119 +++++++++++
 tb/tb_ccip_intr_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_intr_scheduler.sv
// Interrupt scheduler for the CCI-P c1 TX path: latches per-source requests,
// issues them round-robin under c1TxAlmFull, and tracks one response per interrupt id.
module ccip_intr_scheduler #(
  parameter int NUM_SRC     = 4,
  parameter int RSP_TIMEOUT = 4096
) (
  input  logic               Clk_400,
  input  logic               SoftReset,
  input  logic [NUM_SRC-1:0] src_req,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic               tx_almfull,
  output logic               tx_intr_valid,
  output logic [1:0]         tx_intr_id,
  input  logic               rx_rsp_valid,
  input  logic [1:0]         rx_rsp_id,
  output logic [NUM_SRC-1:0] src_ack,
  input  logic               err_clear,
  output logic [NUM_SRC-1:0] pending_o,
  output logic [NUM_SRC-1:0] inflight_o,
  output logic [NUM_SRC-1:0] err_timeout,
  output logic               err_spurious
);

  localparam int             TW      = $clog2(RSP_TIMEOUT) + 1;
  localparam logic [TW-1:0]  T_LAST  = TW'(RSP_TIMEOUT - 1);
  localparam logic [TW-1:0]  T_MAX   = {TW{1'b1}};
  localparam logic [TW-1:0]  T_ONE   = TW'(1);
  localparam logic [1:0]     RR_INIT = 2'(NUM_SRC - 1);

  logic [NUM_SRC-1:0] pending_r;
  logic [NUM_SRC-1:0] inflight_r;
  logic [TW-1:0]      timer_r [NUM_SRC];
  logic [1:0]         rr_ptr_r;

  logic [NUM_SRC-1:0] eligible_s;
  logic [NUM_SRC-1:0] issue_s;
  logic [NUM_SRC-1:0] rsp_hit_s;
  logic [NUM_SRC-1:0] timeout_s;
  logic [1:0]         winner_s;
  logic [1:0]         sel_s;
  logic               take_s;
  logic               fire_s;
  logic               spurious_s;

  // Round-robin pick: first eligible index after the last winner, blocked by almfull
  always_comb begin
    eligible_s = pending_r & ~inflight_r & src_en;
    issue_s    = '0;
    winner_s   = 2'b00;
    fire_s     = 1'b0;
    sel_s      = 2'b00;
    take_s     = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      sel_s          = 2'((int'(rr_ptr_r) + k) % NUM_SRC);
      take_s         = eligible_s[sel_s] & ~fire_s & ~tx_almfull;
      issue_s[sel_s] = take_s;
      winner_s       = take_s ? sel_s : winner_s;
      fire_s         = fire_s | take_s;
    end
  end

  // Response decode and timeout detection; a matching response beats a same-cycle timeout
  always_comb begin
    rsp_hit_s = '0;
    timeout_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rsp_hit_s[i] = rx_rsp_valid & (rx_rsp_id == 2'(i)) & inflight_r[i];
      timeout_s[i] = inflight_r[i] & (timer_r[i] == T_LAST) & ~rsp_hit_s[i];
    end
    spurious_s = rx_rsp_valid & ~(|rsp_hit_s);
  end

  // Per-source request/flight state, round-robin pointer and response timers
  always_ff @(posedge Clk_400) begin
    if (SoftReset) begin
      pending_r  <= '0;
      inflight_r <= '0;
      rr_ptr_r   <= RR_INIT;
      for (int i = 0; i < NUM_SRC; i++) begin
        timer_r[i] <= '0;
      end
    end else begin
      // A request arriving in the issue cycle survives for a later re-issue
      pending_r  <= src_en & ((pending_r & ~issue_s) | src_req);
      inflight_r <= issue_s | (inflight_r & ~rsp_hit_s & ~timeout_s);
      rr_ptr_r   <= fire_s ? winner_s : rr_ptr_r;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (issue_s[i]) begin
          timer_r[i] <= '0;
        end else if (inflight_r[i] && (timer_r[i] != T_MAX)) begin
          timer_r[i] <= timer_r[i] + T_ONE;
        end else begin
          timer_r[i] <= timer_r[i];
        end
      end
    end
  end

  // Registered request/ack pulses and sticky error flags (a new error beats err_clear)
  always_ff @(posedge Clk_400) begin
    if (SoftReset) begin
      tx_intr_valid <= 1'b0;
      tx_intr_id    <= 2'b00;
      src_ack       <= '0;
      err_timeout   <= '0;
      err_spurious  <= 1'b0;
    end else begin
      tx_intr_valid <= fire_s;
      tx_intr_id    <= winner_s;
      src_ack       <= rsp_hit_s;
      err_timeout   <= (err_timeout & ~{NUM_SRC{err_clear}}) | timeout_s;
      err_spurious  <= (err_spurious & ~err_clear) | spurious_s;
    end
  end

  assign pending_o  = pending_r;
  assign inflight_o = inflight_r;

endmodule

// File: tb/tb_ccip_intr_scheduler.sv
// Scoreboard bench for ccip_intr_scheduler: a behavioural model predicts issues and
// acks into queues, a negedge monitor pops and compares them as the DUT presents them.
module tb_ccip_intr_scheduler;

  localparam int N  = 4;
  localparam int TO = 16;

  logic         Clk_400 = 1'b0;
  logic         SoftReset = 1'b0;
  logic [N-1:0] src_req = '0;
  logic [N-1:0] src_en = '0;
  logic         tx_almfull = 1'b0;
  logic         tx_intr_valid;
  logic [1:0]   tx_intr_id;
  logic         rx_rsp_valid = 1'b0;
  logic [1:0]   rx_rsp_id = 2'b00;
  logic [N-1:0] src_ack;
  logic         err_clear = 1'b0;
  logic [N-1:0] pending_o;
  logic [N-1:0] inflight_o;
  logic [N-1:0] err_timeout;
  logic         err_spurious;

  ccip_intr_scheduler #(.NUM_SRC(N), .RSP_TIMEOUT(TO)) dut (
    .Clk_400(Clk_400), .SoftReset(SoftReset), .src_req(src_req), .src_en(src_en),
    .tx_almfull(tx_almfull), .tx_intr_valid(tx_intr_valid), .tx_intr_id(tx_intr_id),
    .rx_rsp_valid(rx_rsp_valid), .rx_rsp_id(rx_rsp_id), .src_ack(src_ack),
    .err_clear(err_clear), .pending_o(pending_o), .inflight_o(inflight_o),
    .err_timeout(err_timeout), .err_spurious(err_spurious)
  );

  always #5 Clk_400 = ~Clk_400;

  int cyc = 0;
  always @(posedge Clk_400) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { int cyc; int val; } rec_t;
  rec_t issue_q[$];
  rec_t ack_q[$];
  int   seen_q[$];
  rec_t mon_r;
  bit   mon_en = 1'b0;

  // Reference model state: what each source is doing, in plain terms
  logic [N-1:0] m_pend, m_fl, m_to;
  logic         m_sp;
  int           m_age [N];
  int           m_rr;
  int           rsp_fifo[$];

  task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] en, input logic af,
                            input logic rv, input logic [1:0] rid, input logic ec, input logic rst);
    int win, hit;
    bit sp, to;
    if (rst) begin
      m_pend = '0; m_fl = '0; m_to = '0; m_sp = 1'b0; m_rr = N - 1;
      for (int s = 0; s < N; s++) m_age[s] = 0;
      rsp_fifo.delete();
      return;
    end
    win = -1;
    if (!af) begin
      for (int k = 1; k <= N; k++) begin
        int s;
        s = (m_rr + k) % N;
        if (m_pend[s] && !m_fl[s] && en[s]) begin win = s; break; end
      end
    end
    hit = -1; sp = 1'b0;
    if (rv) begin
      if (int'(rid) < N && m_fl[rid]) hit = int'(rid);
      else sp = 1'b1;
    end
    if (ec) begin m_to = '0; m_sp = 1'b0; end
    if (sp) m_sp = 1'b1;
    for (int s = 0; s < N; s++) begin
      to = m_fl[s] && (m_age[s] == TO - 1) && (s != hit);
      if (m_fl[s]) m_age[s]++;
      if (s == hit) m_fl[s] = 1'b0;
      if (to) begin m_fl[s] = 1'b0; m_to[s] = 1'b1; end
      m_pend[s] = en[s] & ((m_pend[s] & (s != win)) | req[s]);
    end
    if (hit >= 0) ack_q.push_back('{cyc + 1, 1 << hit});
    if (win >= 0) begin
      m_fl[win] = 1'b1; m_age[win] = 0; m_rr = win;
      issue_q.push_back('{cyc + 1, win});
      rsp_fifo.push_back(win);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT issues or acks, or when one falls due
  always @(negedge Clk_400) begin
    if (mon_en) begin
      if (tx_intr_valid === 1'b1) begin
        seen_q.push_back(int'(tx_intr_id));
        if (issue_q.size() == 0) chk("unexpected_issue_id", int'(tx_intr_id), -1);
        else begin
          mon_r = issue_q.pop_front();
          chk("issue_cycle", cyc, mon_r.cyc);
          chk("issue_id", int'(tx_intr_id), mon_r.val);
        end
      end else if (issue_q.size() > 0 && issue_q[0].cyc <= cyc) begin
        mon_r = issue_q.pop_front();
        chk("issue_valid", int'(tx_intr_valid), 1);
      end
      if (src_ack !== '0) begin
        if (ack_q.size() == 0) chk("unexpected_ack", int'(src_ack), 0);
        else begin
          mon_r = ack_q.pop_front();
          chk("ack_cycle", cyc, mon_r.cyc);
          chk("ack_mask", int'(src_ack), mon_r.val);
        end
      end else if (ack_q.size() > 0 && ack_q[0].cyc <= cyc) begin
        mon_r = ack_q.pop_front();
        chk("ack_mask_missing", int'(src_ack), mon_r.val);
      end
    end
  end

  logic [N-1:0] en_v = '1;
  logic         af_v = 1'b0;

  task automatic step(input logic [N-1:0] req, input logic rv, input logic [1:0] rid,
                      input logic ec, input logic rst);
    src_req = req; src_en = en_v; tx_almfull = af_v;
    rx_rsp_valid = rv; rx_rsp_id = rid; err_clear = ec; SoftReset = rst;
    model_step(req, en_v, af_v, rv, rid, ec, rst);
    @(posedge Clk_400);
    @(negedge Clk_400);
    #1;
    chk("pending_o", int'(pending_o), int'(m_pend));
    chk("inflight_o", int'(inflight_o), int'(m_fl));
    chk("err_timeout", int'(err_timeout), int'(m_to));
    chk("err_spurious", int'(err_spurious), int'(m_sp));
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic reset_dut();
    step('0, 1'b0, 2'b00, 1'b0, 1'b1);
  endtask

  logic [N-1:0] r_req;
  logic         r_rv, r_ec, r_rst;
  logic [1:0]   r_rid;
  int           r_pick, fid;

  initial begin
    @(negedge Clk_400);
    reset_dut();
    reset_dut();
    mon_en = 1'b1;
    chk("rst_valid", int'(tx_intr_valid), 0);
    chk("rst_ack", int'(src_ack), 0);
    chk("rst_pending", int'(pending_o), 0);

    // Single request, issue, response five cycles later
    step(4'b0001, 1'b0, 2'b00, 1'b0, 1'b0);
    idle(1);
    chk("s1_valid", int'(tx_intr_valid), 1);
    chk("s1_id", int'(tx_intr_id), 0);
    idle(4);
    step('0, 1'b1, 2'd0, 1'b0, 1'b0);
    chk("s1_ack", int'(src_ack), 1);
    chk("s1_inflight", int'(inflight_o), 0);

    // All four at once: back-to-back ids 0..3, then coalesced re-requests stay pending
    reset_dut();
    seen_q.delete();
    step(4'hF, 1'b0, 2'b00, 1'b0, 1'b0);
    idle(4);
    chk("s2_count", seen_q.size(), 4);
    for (int k = 0; k < 4 && k < seen_q.size(); k++) chk("s2_order", seen_q[k], k);
    step(4'hF, 1'b0, 2'b00, 1'b0, 1'b0);
    idle(2);
    chk("s2_pending", int'(pending_o), 15);
    chk("s2_no_reissue", seen_q.size(), 4);

    // Almfull backpressure for ten cycles, then issue the cycle after it falls
    reset_dut();
    af_v = 1'b1;
    step(4'b0100, 1'b0, 2'b00, 1'b0, 1'b0);
    idle(9);
    chk("s3_blocked", int'(tx_intr_valid), 0);
    chk("s3_pending", int'(pending_o), 4);
    af_v = 1'b0;
    idle(1);
    chk("s3_valid", int'(tx_intr_valid), 1);
    chk("s3_id", int'(tx_intr_id), 2);

    // Timeout of id 1, then err_clear
    reset_dut();
    step(4'b0010, 1'b0, 2'b00, 1'b0, 1'b0);
    idle(1);
    chk("s4_id", int'(tx_intr_id), 1);
    idle(TO - 1);
    chk("s4_not_yet", int'(err_timeout), 0);
    idle(1);
    chk("s4_timeout", int'(err_timeout), 2);
    chk("s4_inflight", int'(inflight_o), 0);
    step('0, 1'b0, 2'b00, 1'b1, 1'b0);
    chk("s4_cleared", int'(err_timeout), 0);

    // Spurious response, then response on the timeout cycle wins
    step('0, 1'b1, 2'd3, 1'b0, 1'b0);
    chk("s5_spurious", int'(err_spurious), 1);
    step('0, 1'b0, 2'b00, 1'b1, 1'b0);
    step(4'b0001, 1'b0, 2'b00, 1'b0, 1'b0);
    idle(1);
    idle(TO - 1);
    step('0, 1'b1, 2'd0, 1'b0, 1'b0);
    chk("s5_ack", int'(src_ack), 1);
    chk("s5_no_timeout", int'(err_timeout), 0);

    // Fairness between two held requests, responded to in issue order
    reset_dut();
    seen_q.delete();
    repeat (14) begin
      if (rsp_fifo.size() > 0 && m_fl[rsp_fifo[0]]) begin
        fid = rsp_fifo.pop_front();
        step(4'b0011, 1'b1, 2'(fid), 1'b0, 1'b0);
      end else begin
        step(4'b0011, 1'b0, 2'b00, 1'b0, 1'b0);
      end
    end
    chk("fair_enough_issues", int'(seen_q.size() >= 8), 1);
    if (seen_q.size() > 0) chk("fair_first", seen_q[0], 0);
    for (int k = 1; k < seen_q.size() && k < 8; k++) chk("fair_alternate", seen_q[k], 1 - seen_q[k-1]);

    // Reset with id 1 in flight; its late response is spurious
    idle(3);
    chk("s6_id1_inflight", int'(inflight_o[1]), 1);
    reset_dut();
    chk("s6_rst_inflight", int'(inflight_o), 0);
    chk("s6_rst_pending", int'(pending_o), 0);
    step('0, 1'b1, 2'd1, 1'b0, 1'b0);
    chk("s6_late_spurious", int'(err_spurious), 1);

    // Randomised traffic against the model
    for (int t = 0; t < 3000; t++) begin
      r_req = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) en_v = N'($urandom_range(0, 15) | $urandom_range(0, 15));
      af_v = ($urandom_range(0, 4) == 0);
      r_rv = 1'b0; r_rid = 2'b00;
      r_pick = $urandom_range(0, N - 1);
      if ($urandom_range(0, 2) == 0 && m_fl[r_pick]) begin
        r_rv = 1'b1; r_rid = 2'(r_pick);
      end else if ($urandom_range(0, 29) == 0) begin
        r_rv = 1'b1; r_rid = 2'($urandom_range(0, 3));
      end
      r_ec  = ($urandom_range(0, 39) == 0);
      r_rst = ($urandom_range(0, 399) == 0);
      step(r_req, r_rv, r_rid, r_ec, r_rst);
    end

    en_v = '1; af_v = 1'b0;
    reset_dut();
    idle(3);
    chk("issue_q_drained", issue_q.size(), 0);
    chk("ack_q_drained", ack_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
